// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: captures execute-stage results, resolves taken branches into a
// single-cycle PCSrc pulse, and keeps a saturating count of bubbles entering MEM.
module ex_mem_latch #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned REGBITS = 5,
   parameter int unsigned CNTBITS = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               ex_valid,
   input  logic [WIDTH-1:0]   ex_alu_result,
   input  logic               ex_alu_zero,
   input  logic [WIDTH-1:0]   ex_rt_data,
   input  logic [WIDTH-1:0]   ex_npc,
   input  logic [WIDTH-1:0]   ex_imm,
   input  logic [REGBITS-1:0] ex_dest_reg,
   input  logic               ex_regwrite,
   input  logic               ex_memtoreg,
   input  logic               ex_branch,
   input  logic               ex_memread,
   input  logic               ex_memwrite,
   output logic               mem_valid,
   output logic [WIDTH-1:0]   mem_alu_result,
   output logic [WIDTH-1:0]   mem_rt_data,
   output logic [WIDTH-1:0]   mem_branch_target,
   output logic               mem_alu_zero,
   output logic [REGBITS-1:0] mem_dest_reg,
   output logic               mem_regwrite,
   output logic               mem_memtoreg,
   output logic               mem_memread,
   output logic               mem_memwrite,
   output logic               mem_pcsrc,
   output logic [CNTBITS-1:0] bubble_count
);

   typedef enum logic {StIdle, StFired} fire_e;

   fire_e              fire_q, fire_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   alu_result_q, alu_result_d;
   logic [WIDTH-1:0]   rt_data_q, rt_data_d;
   logic [WIDTH-1:0]   target_q, target_d;
   logic               alu_zero_q, alu_zero_d;
   logic [REGBITS-1:0] dest_reg_q, dest_reg_d;
   logic               regwrite_q, regwrite_d;
   logic               memtoreg_q, memtoreg_d;
   logic               memread_q, memread_d;
   logic               memwrite_q, memwrite_d;
   logic               branch_q, branch_d;
   logic               pcsrc_q, pcsrc_d;
   logic [CNTBITS-1:0] cnt_q, cnt_d;
   logic [CNTBITS-1:0] cnt_inc;
   logic [WIDTH-1:0]   target;

   assign target  = ex_npc + (ex_imm << 2);
   assign cnt_inc = (cnt_q == {CNTBITS{1'b1}}) ? cnt_q : cnt_q + CNTBITS'(1);

   always_comb begin
      fire_d       = fire_q;
      valid_d      = valid_q;
      alu_result_d = alu_result_q;
      rt_data_d    = rt_data_q;
      target_d     = target_q;
      alu_zero_d   = alu_zero_q;
      dest_reg_d   = dest_reg_q;
      regwrite_d   = regwrite_q;
      memtoreg_d   = memtoreg_q;
      memread_d    = memread_q;
      memwrite_d   = memwrite_q;
      branch_d     = branch_q;
      cnt_d        = cnt_q;
      if (flush) begin
         fire_d       = StIdle;
         valid_d      = 1'b0;
         alu_result_d = '0;
         rt_data_d    = '0;
         target_d     = '0;
         alu_zero_d   = 1'b0;
         dest_reg_d   = '0;
         regwrite_d   = 1'b0;
         memtoreg_d   = 1'b0;
         memread_d    = 1'b0;
         memwrite_d   = 1'b0;
         branch_d     = 1'b0;
         cnt_d        = cnt_inc;
      end else if (!stall) begin
         fire_d       = StIdle;
         valid_d      = ex_valid;
         alu_result_d = ex_alu_result;
         rt_data_d    = ex_rt_data;
         target_d     = target;
         alu_zero_d   = ex_alu_zero;
         dest_reg_d   = ex_dest_reg;
         // A bubble must never write state or redirect fetch.
         regwrite_d   = ex_valid & ex_regwrite;
         memtoreg_d   = ex_valid & ex_memtoreg;
         memread_d    = ex_valid & ex_memread;
         memwrite_d   = ex_valid & ex_memwrite;
         branch_d     = ex_valid & ex_branch;
         if (!ex_valid) cnt_d = cnt_inc;
      end else if (pcsrc_q) begin
         fire_d = StFired;
      end
      // Registered so the pulse is a pure flop output with no input-to-output path.
      pcsrc_d = branch_d & alu_zero_d & valid_d & (fire_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fire_q       <= StIdle;
         valid_q      <= 1'b0;
         alu_result_q <= '0;
         rt_data_q    <= '0;
         target_q     <= '0;
         alu_zero_q   <= 1'b0;
         dest_reg_q   <= '0;
         regwrite_q   <= 1'b0;
         memtoreg_q   <= 1'b0;
         memread_q    <= 1'b0;
         memwrite_q   <= 1'b0;
         branch_q     <= 1'b0;
         pcsrc_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         fire_q       <= fire_d;
         valid_q      <= valid_d;
         alu_result_q <= alu_result_d;
         rt_data_q    <= rt_data_d;
         target_q     <= target_d;
         alu_zero_q   <= alu_zero_d;
         dest_reg_q   <= dest_reg_d;
         regwrite_q   <= regwrite_d;
         memtoreg_q   <= memtoreg_d;
         memread_q    <= memread_d;
         memwrite_q   <= memwrite_d;
         branch_q     <= branch_d;
         pcsrc_q      <= pcsrc_d;
         cnt_q        <= cnt_d;
      end
   end

   assign mem_valid         = valid_q;
   assign mem_alu_result    = alu_result_q;
   assign mem_rt_data       = rt_data_q;
   assign mem_branch_target = target_q;
   assign mem_alu_zero      = alu_zero_q;
   assign mem_dest_reg      = dest_reg_q;
   assign mem_regwrite      = regwrite_q;
   assign mem_memtoreg      = memtoreg_q;
   assign mem_memread       = memread_q;
   assign mem_memwrite      = memwrite_q;
   assign mem_pcsrc         = pcsrc_q;
   assign bubble_count      = cnt_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomized bench for ex_mem_latch against a behavioural model of the MEM-stage contents,
// with a 4-bit-counter instance alongside to exercise bubble-count saturation.
module tb_ex_mem_latch;

   logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
   logic        ex_valid = 1'b0, ex_alu_zero = 1'b0;
   logic [31:0] ex_alu_result = '0, ex_rt_data = '0, ex_npc = '0, ex_imm = '0;
   logic [4:0]  ex_dest_reg = '0;
   logic        ex_regwrite = 1'b0, ex_memtoreg = 1'b0, ex_branch = 1'b0;
   logic        ex_memread = 1'b0, ex_memwrite = 1'b0;

   logic        mem_valid, mem_alu_zero, mem_regwrite, mem_memtoreg, mem_memread;
   logic        mem_memwrite, mem_pcsrc;
   logic [31:0] mem_alu_result, mem_rt_data, mem_branch_target;
   logic [4:0]  mem_dest_reg;
   logic [15:0] bubble_count;

   logic        d4_valid, d4_alu_zero, d4_regwrite, d4_memtoreg, d4_memread;
   logic        d4_memwrite, d4_pcsrc;
   logic [31:0] d4_alu_result, d4_rt_data, d4_branch_target;
   logic [4:0]  d4_dest_reg;
   logic [3:0]  d4_bubble_count;

   int vectors = 0, miscompares = 0;
   bit chk_en = 1'b0;

   // Model of what MEM holds: contents, whether it is a taken branch, cycles held, bubbles seen.
   bit          m_valid, m_zero, m_rw, m_m2r, m_mr, m_mw, m_taken;
   logic [31:0] m_alu, m_rt, m_tgt;
   logic [4:0]  m_dest;
   int          m_age, m_nb;

   ex_mem_latch dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_alu_zero(ex_alu_zero), .ex_rt_data(ex_rt_data),
      .ex_npc(ex_npc), .ex_imm(ex_imm), .ex_dest_reg(ex_dest_reg), .ex_regwrite(ex_regwrite),
      .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
      .mem_rt_data(mem_rt_data), .mem_branch_target(mem_branch_target),
      .mem_alu_zero(mem_alu_zero), .mem_dest_reg(mem_dest_reg), .mem_regwrite(mem_regwrite),
      .mem_memtoreg(mem_memtoreg), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .mem_pcsrc(mem_pcsrc), .bubble_count(bubble_count)
   );

   ex_mem_latch #(.CNTBITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_alu_zero(ex_alu_zero), .ex_rt_data(ex_rt_data),
      .ex_npc(ex_npc), .ex_imm(ex_imm), .ex_dest_reg(ex_dest_reg), .ex_regwrite(ex_regwrite),
      .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .mem_valid(d4_valid), .mem_alu_result(d4_alu_result),
      .mem_rt_data(d4_rt_data), .mem_branch_target(d4_branch_target),
      .mem_alu_zero(d4_alu_zero), .mem_dest_reg(d4_dest_reg), .mem_regwrite(d4_regwrite),
      .mem_memtoreg(d4_memtoreg), .mem_memread(d4_memread), .mem_memwrite(d4_memwrite),
      .mem_pcsrc(d4_pcsrc), .bubble_count(d4_bubble_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      {m_valid, m_zero, m_rw, m_m2r, m_mr, m_mw, m_taken} = '0;
      m_alu = '0; m_rt = '0; m_tgt = '0; m_dest = '0; m_age = 0; m_nb = 0;
   endtask

   task automatic model_step();
      if (flush) begin
         {m_valid, m_zero, m_rw, m_m2r, m_mr, m_mw, m_taken} = '0;
         m_alu = '0; m_rt = '0; m_tgt = '0; m_dest = '0; m_age = 0; m_nb++;
      end else if (!stall) begin
         m_valid = ex_valid;  m_alu = ex_alu_result; m_rt = ex_rt_data; m_zero = ex_alu_zero;
         m_tgt   = ex_npc + ex_imm * 4;  m_dest = ex_dest_reg;
         m_rw    = ex_valid && ex_regwrite;  m_m2r = ex_valid && ex_memtoreg;
         m_mr    = ex_valid && ex_memread;   m_mw  = ex_valid && ex_memwrite;
         m_taken = ex_valid && ex_branch && ex_alu_zero;
         m_age   = 0;
         if (!ex_valid) m_nb++;
      end else begin
         m_age++;
      end
   endtask

   always @(negedge rst_n) model_reset();
   always @(posedge clk) if (rst_n) model_step();

   task automatic cmp_set(input string p, input logic v, input logic [31:0] alu,
                          input logic z, input logic [31:0] rt, input logic [31:0] tgt,
                          input logic [4:0] dst, input logic rw, input logic m2r,
                          input logic mr, input logic mw, input logic pc,
                          input logic [15:0] cnt, input int sat);
      chk({p, "valid"}, 64'(v), 64'(m_valid));
      chk({p, "alu_result"}, 64'(alu), 64'(m_alu));
      chk({p, "alu_zero"}, 64'(z), 64'(m_zero));
      chk({p, "rt_data"}, 64'(rt), 64'(m_rt));
      chk({p, "branch_target"}, 64'(tgt), 64'(m_tgt));
      chk({p, "dest_reg"}, 64'(dst), 64'(m_dest));
      chk({p, "regwrite"}, 64'(rw), 64'(m_rw));
      chk({p, "memtoreg"}, 64'(m2r), 64'(m_m2r));
      chk({p, "memread"}, 64'(mr), 64'(m_mr));
      chk({p, "memwrite"}, 64'(mw), 64'(m_mw));
      chk({p, "pcsrc"}, 64'(pc), 64'(m_taken && m_age == 0));
      chk({p, "bubble_count"}, 64'(cnt), 64'((m_nb > sat) ? sat : m_nb));
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         cmp_set("m16 ", mem_valid, mem_alu_result, mem_alu_zero, mem_rt_data,
                 mem_branch_target, mem_dest_reg, mem_regwrite, mem_memtoreg, mem_memread,
                 mem_memwrite, mem_pcsrc, bubble_count, 65535);
         cmp_set("m4 ", d4_valid, d4_alu_result, d4_alu_zero, d4_rt_data, d4_branch_target,
                 d4_dest_reg, d4_regwrite, d4_memtoreg, d4_memread, d4_memwrite, d4_pcsrc,
                 16'(d4_bubble_count), 15);
      end
   end

   task automatic chk_zero(input string p);
      chk({p, " valid"}, 64'(mem_valid), 0);
      chk({p, " alu_result"}, 64'(mem_alu_result), 0);
      chk({p, " rt_data"}, 64'(mem_rt_data), 0);
      chk({p, " branch_target"}, 64'(mem_branch_target), 0);
      chk({p, " zero/dest/ctrl"}, 64'({mem_alu_zero, mem_dest_reg, mem_regwrite, mem_memtoreg,
                                        mem_memread, mem_memwrite, mem_pcsrc}), 0);
      chk({p, " bubble_count"}, 64'(bubble_count), 0);
      chk({p, " d4 bubble_count"}, 64'(d4_bubble_count), 0);
   endtask

   task automatic set_ex(input logic v, input logic [31:0] alu, input logic z,
                         input logic [31:0] rt, input logic [31:0] npc, input logic [31:0] imm,
                         input logic [4:0] dst, input logic rw, input logic m2r,
                         input logic br, input logic mr, input logic mw);
      ex_valid = v; ex_alu_result = alu; ex_alu_zero = z; ex_rt_data = rt; ex_npc = npc;
      ex_imm = imm; ex_dest_reg = dst; ex_regwrite = rw; ex_memtoreg = m2r; ex_branch = br;
      ex_memread = mr; ex_memwrite = mw;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      set_ex($urandom_range(0, 3) != 0, $urandom, 1'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
   endtask

   initial begin
      model_reset();
      #3;
      chk_zero("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      set_ex(1, 32'h10, 0, 32'h55, 32'h0040_0004, 32'hFFFF_FFFF, 9, 1, 0, 0, 0, 0);
      cyc();
      chk("load alu_result", 64'(mem_alu_result), 64'h10);
      chk("load branch_target", 64'(mem_branch_target), 64'h0040_0000);
      chk("load dest_reg", 64'(mem_dest_reg), 9);
      chk("load regwrite", 64'(mem_regwrite), 1);
      chk("load valid", 64'(mem_valid), 1);

      set_ex(1, 32'h20, 0, 0, 32'hFFFF_FFFC, 32'h2, 3, 1, 0, 0, 0, 0);
      cyc();
      chk("wrap branch_target", 64'(mem_branch_target), 64'h4);

      set_ex(1, 32'h0, 1, 0, 32'h100, 32'h4, 0, 0, 0, 1, 0, 0);
      cyc();
      chk("branch pcsrc", 64'(mem_pcsrc), 1);
      chk("branch target", 64'(mem_branch_target), 64'h110);
      stall = 1'b1;
      set_ex(1, 32'hDEAD, 1, 7, 32'h900, 32'h1, 4, 1, 1, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall pcsrc low", 64'(mem_pcsrc), 0);
         chk("stall alu held", 64'(mem_alu_result), 0);
         chk("stall target held", 64'(mem_branch_target), 64'h110);
         chk("stall valid held", 64'(mem_valid), 1);
      end
      stall = 1'b0;

      set_ex(1, 32'h0, 1, 0, 32'h200, 32'h1, 0, 0, 0, 1, 0, 0);
      cyc();
      chk("b2b first pcsrc", 64'(mem_pcsrc), 1);
      set_ex(1, 32'h0, 1, 0, 32'h300, 32'h0, 0, 0, 0, 1, 0, 0);
      cyc();
      chk("b2b second pcsrc", 64'(mem_pcsrc), 1);
      chk("b2b second target", 64'(mem_branch_target), 64'h300);

      flush = 1'b1;
      set_ex(1, 32'h0, 1, 0, 32'h400, 32'h1, 0, 0, 0, 1, 0, 0);
      cyc();
      chk("flush branch pcsrc", 64'(mem_pcsrc), 0);
      chk("flush branch bubbles", 64'(bubble_count), 1);

      stall = 1'b1;
      set_ex(1, 32'hABCD, 0, 32'h77, 32'h0, 32'h0, 5, 0, 0, 0, 0, 1);
      cyc();
      chk("prio valid", 64'(mem_valid), 0);
      chk("prio memwrite", 64'(mem_memwrite), 0);
      chk("prio alu_result", 64'(mem_alu_result), 0);
      chk("prio bubbles", 64'(bubble_count), 2);
      stall = 1'b0;

      repeat (20) cyc();
      chk("sat d4 bubble_count", 64'(d4_bubble_count), 15);
      chk("sat m16 bubble_count", 64'(bubble_count), 22);
      flush = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         if (i == 1500) begin
            stall = 1'b1;
            #2 rst_n = 1'b0;
            #1 chk_zero("async reset");
            #1 rst_n = 1'b1;
         end
         cyc();
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
